ifetch_unit: RTL and testbench

- Parametrised instruction fetch stage for the next-generation multicycle RV32 core; replaces the core's bare pc/ir register pair.
- Owns the fetch PC with a configurable reset vector.
- Issues word reads over a req/ack memory handshake and buffers fetched words with their PCs in a DEPTH-entry prefetch queue.
- Presents instructions to the decoder over a valid/ready interface; a redirect input handles branches and jumps by flushing the queue.

---
 rtl/ifetch_unit.sv | 138 +++++++++++++
 tb/tb_ifetch_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - RV32 fetch stage: PC, req/ack word fetch, prefetch queue, redirect flush
module ifetch_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int              DEPTH     = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ce,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    state_t          state, state_n;
    logic [XLEN-1:0] fetch_pc, fetch_pc_n;
    logic [XLEN-1:0] addr_q, addr_n;
    logic [XLEN-1:0] q_instr [DEPTH];
    logic [XLEN-1:0] q_pc    [DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count, count_next;
    logic            xfer, push, pop, space;
    logic [XLEN-1:0] redir_pc;

    assign mem_req     = (state != IDLE);
    assign mem_addr    = addr_q;
    assign instr_valid = (count != '0) && !redirect_valid;
    assign instr       = q_instr[rd_ptr];
    assign instr_pc    = q_pc[rd_ptr];

    assign xfer       = mem_req && mem_ack;
    assign pop        = instr_valid && instr_ready;
    // Only a live REQ transfer outside a redirect cycle carries usable data.
    assign push       = (state == REQ) && xfer && !redirect_valid;
    assign count_next = count - {{(CW-1){1'b0}}, pop} + {{(CW-1){1'b0}}, push};
    assign space      = count_next < CW'(DEPTH);
    assign redir_pc   = {redirect_pc[XLEN-1:2], 2'b00};

    always_comb begin
        state_n    = state;
        fetch_pc_n = fetch_pc;
        addr_n     = addr_q;
        case (state)
            IDLE: begin
                if (redirect_valid) begin
                    fetch_pc_n = redir_pc;
                end else if (ce && space) begin
                    state_n = REQ;
                    addr_n  = fetch_pc;
                end
            end
            REQ: begin
                if (redirect_valid) begin
                    fetch_pc_n = redir_pc;
                    if (xfer) begin
                        if (ce) begin
                            addr_n = redir_pc;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        state_n = DRAIN;
                    end
                end else if (xfer) begin
                    fetch_pc_n = fetch_pc + XLEN'(4);
                    if (ce && space) begin
                        addr_n = fetch_pc + XLEN'(4);
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            DRAIN: begin
                // Address stays on the stale request until it is acked.
                if (redirect_valid) begin
                    fetch_pc_n = redir_pc;
                end
                if (xfer) begin
                    if (ce) begin
                        state_n = REQ;
                        addr_n  = fetch_pc_n;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            fetch_pc <= RESET_VEC;
            addr_q   <= RESET_VEC;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_instr[i] <= '0;
                q_pc[i]    <= '0;
            end
        end else begin
            state    <= state_n;
            fetch_pc <= fetch_pc_n;
            addr_q   <= addr_n;
            if (redirect_valid) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                count <= count_next;
                if (push) begin
                    q_instr[wr_ptr] <= mem_rdata;
                    q_pc[wr_ptr]    <= fetch_pc;
                    wr_ptr          <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
            end
        end
    end

    a_no_push_when_full: assert property (@(posedge clk) disable iff (reset)
        !(push && count == CW'(DEPTH)));
endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - self-checking bench for ifetch_unit with memory model and scoreboard
module tb_ifetch_unit;
    logic        clk = 1'b0;
    logic        reset, ce, mem_req, mem_ack, redirect_valid, instr_valid, instr_ready;
    logic [31:0] mem_addr, mem_rdata, redirect_pc, instr, instr_pc;

    always #5 clk = ~clk;

    ifetch_unit #(.XLEN(32), .RESET_VEC(32'h0), .DEPTH(2)) dut (
        .clk(clk), .reset(reset), .ce(ce),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a << 8) ^ a ^ 32'hA5C3_0F96;
    endfunction

    typedef struct { logic [31:0] pc; logic [31:0] data; } sb_t;
    sb_t         sb[$];
    sb_t         e;
    int          ack_delay = 0;
    int          wait_cnt = 0;
    logic        stale = 1'b0;
    logic [31:0] exp_fetch = 32'h0;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    logic        prev_push = 1'b0;
    int          push_count = 0;
    int          pop_count = 0;

    // Memory responder and scoreboard, evaluated mid-cycle.
    initial begin
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            mem_ack   = mem_req && (wait_cnt >= ack_delay);
            mem_rdata = mem_req ? mem_fn(mem_addr) : 32'h0;
            if (reset) begin
                sb.delete();
                exp_fetch = 32'h0;
                stale     = 1'b0;
                wait_cnt  = 0;
                prev_hold = 1'b0;
                prev_push = 1'b0;
            end else begin
                if (prev_hold) begin
                    chk("req_held", {31'b0, mem_req}, 32'h1);
                    chk("addr_stable", mem_addr, prev_addr);
                end
                if (prev_push && !redirect_valid)
                    chk("valid_after_push", {31'b0, instr_valid}, 32'h1);
                if (redirect_valid)
                    chk("valid_masked", {31'b0, instr_valid}, 32'h0);
                if (instr_valid && instr_ready) begin
                    pop_count++;
                    if (sb.size() == 0) begin
                        chk("pop_unexpected", {31'b0, instr_valid}, 32'h0);
                    end else begin
                        e = sb.pop_front();
                        chk("instr_pc", instr_pc, e.pc);
                        chk("instr", instr, e.data);
                    end
                end
                prev_push = 1'b0;
                if (mem_req && mem_ack) begin
                    if (redirect_valid || stale) begin
                        stale = 1'b0;
                    end else begin
                        chk("fetch_addr", mem_addr, exp_fetch);
                        sb.push_back('{exp_fetch, mem_fn(exp_fetch)});
                        exp_fetch = exp_fetch + 32'd4;
                        push_count++;
                        prev_push = 1'b1;
                    end
                end
                if (redirect_valid) begin
                    sb.delete();
                    exp_fetch = redirect_pc & ~32'h3;
                    if (mem_req && !mem_ack) stale = 1'b1;
                end
                prev_hold = mem_req && !mem_ack;
                prev_addr = mem_addr;
                wait_cnt  = (mem_req && !mem_ack) ? wait_cnt + 1 : 0;
            end
        end
    end

    typedef struct {
        logic        ready;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;
    vec_t tbl[9];

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk_reset_outputs();
        reset = 1'b0;
    endtask

    task automatic wait_valid(input string name, input logic [31:0] pc);
        int found = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (instr_valid) begin
                found = 1;
                break;
            end
        end
        chk({name, "_valid"}, found, 32'h1);
        chk({name, "_pc"}, instr_pc, pc);
    endtask

    task automatic wait_fresh_req(input string name);
        int found = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (mem_req && wait_cnt == 0) begin
                found = 1;
                break;
            end
        end
        chk({name, "_found"}, found, 32'h1);
    endtask

    int p0;

    initial begin
        tbl[0] = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0};
        tbl[1] = '{1'b1, 1'b1, 32'h0,  1'b0, 32'h0};
        tbl[2] = '{1'b1, 1'b1, 32'h4,  1'b1, 32'h0};
        tbl[3] = '{1'b1, 1'b1, 32'h8,  1'b1, 32'h4};
        tbl[4] = '{1'b0, 1'b1, 32'hC,  1'b1, 32'h8};
        tbl[5] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h8};
        tbl[6] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h8};
        tbl[7] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'hC};
        tbl[8] = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h10};

        reset = 1'b1; ce = 1'b1; instr_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        cycles(2);
        chk_reset_outputs();
        reset = 1'b0;

        // Reset release latency, streaming and a short backpressure window.
        for (int i = 0; i < 9; i++) begin
            if (i > 0) cycles(1);
            instr_ready = tbl[i].ready;
            @(negedge clk);
            chk($sformatf("tbl%0d_req", i), {31'b0, mem_req}, {31'b0, tbl[i].exp_req});
            if (tbl[i].exp_req) chk($sformatf("tbl%0d_addr", i), mem_addr, tbl[i].exp_addr);
            chk($sformatf("tbl%0d_valid", i), {31'b0, instr_valid}, {31'b0, tbl[i].exp_valid});
            if (tbl[i].exp_valid) chk($sformatf("tbl%0d_pc", i), instr_pc, tbl[i].exp_pc);
        end
        cycles(6);

        // Consumer stalled from reset: queue fills with two words then fetch stops.
        instr_ready = 1'b0;
        do_reset();
        p0 = push_count;
        repeat (8) @(negedge clk);
        chk("stall_pushes", push_count - p0, 32'd2);
        chk("stall_req", {31'b0, mem_req}, 32'h0);
        cycles(1);
        instr_ready = 1'b1;
        p0 = pop_count;
        cycles(12);
        chk("stall_progress", 32'(pop_count >= p0 + 8), 32'h1);

        // Slow memory.
        ack_delay = 3;
        p0 = pop_count;
        cycles(24);
        chk("slow_progress", 32'(pop_count > p0 + 3), 32'h1);

        // Redirect while the request at 0x8 is still waiting.
        do_reset();
        begin
            int found = 0;
            for (int i = 0; i < 60; i++) begin
                @(posedge clk); #1;
                if (mem_req && mem_addr == 32'h8 && wait_cnt == 0) begin
                    found = 1;
                    break;
                end
            end
            chk("req8_found", found, 32'h1);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h103;
        cycles(1);
        redirect_valid = 1'b0;
        chk("drain_req", {31'b0, mem_req}, 32'h1);
        chk("drain_addr", mem_addr, 32'h8);
        wait_valid("redir1", 32'h100);
        cycles(10);

        // Redirect with ack, then redirect into DRAIN and again during DRAIN.
        ack_delay = 0;
        cycles(6);
        chk("redir_ack_req", {31'b0, mem_req}, 32'h1);
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        cycles(1);
        chk("redir_new_addr", mem_addr, 32'h200);
        ack_delay = 3;
        redirect_pc = 32'h300;
        cycles(1);
        chk("drain2_addr", mem_addr, 32'h200);
        redirect_pc = 32'h406;
        cycles(1);
        redirect_valid = 1'b0;
        ack_delay = 0;
        wait_valid("redir2", 32'h404);
        cycles(8);

        // ce drops with a request in flight.
        ack_delay = 2;
        wait_fresh_req("ce_req");
        ce = 1'b0;
        p0 = push_count;
        repeat (6) @(negedge clk);
        chk("ce_low_pushes", push_count - p0, 32'd1);
        chk("ce_low_req", {31'b0, mem_req}, 32'h0);
        cycles(1);
        ce = 1'b1;
        p0 = pop_count;
        cycles(15);
        chk("ce_progress", 32'(pop_count > p0 + 2), 32'h1);

        // PC wraps past the top of the address space.
        ack_delay = 0;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF9;
        cycles(1);
        redirect_valid = 1'b0;
        wait_valid("wrap", 32'hFFFF_FFF8);
        p0 = pop_count;
        cycles(8);
        chk("wrap_progress", 32'(pop_count >= p0 + 6), 32'h1);

        // Reset in the middle of a transfer.
        ack_delay = 3;
        wait_fresh_req("midrst_req");
        do_reset();
        cycles(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
